// File: rtl/alu_rsp_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_rsp_tx
// Brief    : ALU serial-link response serializer; 11-bit frames, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rsp_tx #(
    parameter int IDLE_GAP = 0,
    parameter int RSP_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic        rsp_is_err,
    input  logic [31:0] rsp_data,
    input  logic [3:0]  rsp_flags,
    input  logic [2:0]  rsp_err,
    output logic        sout,
    output logic        busy
);

    localparam int c_GAP_MAX = (IDLE_GAP > RSP_GAP) ? IDLE_GAP : RSP_GAP;
    localparam int c_GW      = (c_GAP_MAX < 2) ? 1 : $clog2(c_GAP_MAX + 1);
    localparam logic [c_GW-1:0] c_IDLE_LD = c_GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [c_GW-1:0] c_TAIL_LD = c_GW'((RSP_GAP > 0) ? RSP_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TYPE  = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_TAIL  = 3'd6
    } state_t;

    // CRC3, x^3+x+1, init 000, MSB first; loop unrolls into a parallel XOR tree
    function automatic logic [2:0] crc3(input logic [36:0] msg);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = msg[i] ^ c[2];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    state_t            r_state;
    logic [39:0]       r_image;
    logic [2:0]        r_bit;
    logic [2:0]        r_byte;
    logic [c_GW-1:0]   r_gap;
    logic              r_is_err;
    logic              r_sout;

    state_t            w_state_nxt;
    logic [39:0]       w_image_nxt;
    logic [2:0]        w_bit_nxt;
    logic [2:0]        w_byte_nxt;
    logic [c_GW-1:0]   w_gap_nxt;
    logic              w_is_err_nxt;
    logic              w_sout_nxt;
    logic [2:0]        w_crc;
    logic              w_par;
    logic [7:0]        w_err_byte;
    logic [2:0]        w_last;

    assign w_crc      = crc3({rsp_data, 1'b0, rsp_flags});
    assign w_par      = ^{1'b1, rsp_err, rsp_err};
    assign w_err_byte = {1'b1, rsp_err, rsp_err, w_par};
    assign w_last     = r_is_err ? 3'd0 : 3'd4;

    always_comb begin
        w_state_nxt  = r_state;
        w_image_nxt  = r_image;
        w_bit_nxt    = r_bit;
        w_byte_nxt   = r_byte;
        w_gap_nxt    = r_gap;
        w_is_err_nxt = r_is_err;
        case (r_state)
            S_IDLE: begin
                if (rsp_valid) begin
                    w_state_nxt  = S_START;
                    w_is_err_nxt = rsp_is_err;
                    w_byte_nxt   = 3'd0;
                    w_image_nxt  = rsp_is_err ? {w_err_byte, 32'h0}
                                              : {rsp_data, 1'b0, rsp_flags, w_crc};
                end
            end
            S_START: w_state_nxt = S_TYPE;
            S_TYPE: begin
                w_state_nxt = S_DATA;
                w_bit_nxt   = 3'd7;
            end
            S_DATA: begin
                w_image_nxt = {r_image[38:0], 1'b0};
                if (r_bit == 3'd0) w_state_nxt = S_STOP;
                else               w_bit_nxt   = r_bit - 3'd1;
            end
            S_STOP: begin
                if (r_byte != w_last) begin
                    w_byte_nxt = r_byte + 3'd1;
                    if (IDLE_GAP > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = c_IDLE_LD;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else if (RSP_GAP > 0) begin
                    w_state_nxt = S_TAIL;
                    w_gap_nxt   = c_TAIL_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == '0) w_state_nxt = S_START;
                else             w_gap_nxt   = r_gap - 1'b1;
            end
            S_TAIL: begin
                if (r_gap == '0) w_state_nxt = S_IDLE;
                else             w_gap_nxt   = r_gap - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // sout is registered alongside the state, so it shows the bit of the state being entered
        case (w_state_nxt)
            S_START: w_sout_nxt = 1'b0;
            S_TYPE:  w_sout_nxt = w_is_err_nxt | (w_byte_nxt == 3'd4);
            S_DATA:  w_sout_nxt = w_image_nxt[39];
            default: w_sout_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_image  <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_gap    <= '0;
            r_is_err <= 1'b0;
            r_sout   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_image  <= w_image_nxt;
            r_bit    <= w_bit_nxt;
            r_byte   <= w_byte_nxt;
            r_gap    <= w_gap_nxt;
            r_is_err <= w_is_err_nxt;
            r_sout   <= w_sout_nxt;
        end
    end

    assign sout      = r_sout;
    assign busy      = (r_state != S_IDLE);
    assign rsp_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rsp_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_rsp_tx
// Brief    : Scoreboard bench for alu_rsp_tx; frame receiver checks every frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rsp_tx;

    localparam int RSP_GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic        is_err = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  flags = '0;
    logic [2:0]  err = '0;
    logic        ready_a, sout_a, busy_a;
    logic        ready_b, sout_b, busy_b;

    always #5 clk = ~clk;

    alu_rsp_tx #(.IDLE_GAP(0), .RSP_GAP(RSP_GAP)) u_dut_a (
        .clk(clk), .rst(rst), .rsp_valid(va), .rsp_ready(ready_a),
        .rsp_is_err(is_err), .rsp_data(data), .rsp_flags(flags), .rsp_err(err),
        .sout(sout_a), .busy(busy_a)
    );

    alu_rsp_tx #(.IDLE_GAP(3), .RSP_GAP(RSP_GAP)) u_dut_b (
        .clk(clk), .rst(rst), .rsp_valid(vb), .rsp_ready(ready_b),
        .rsp_is_err(is_err), .rsp_data(data), .rsp_flags(flags), .rsp_err(err),
        .sout(sout_b), .busy(busy_b)
    );

    typedef struct {
        logic       is_ctl;
        logic [7:0] val;
        int         gap;    // idle bits expected before this frame, -1 = don't care
    } frame_t;

    frame_t qa[$];
    frame_t qb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^3 mod x^3+x+1 by long division
    function automatic logic [2:0] crc_model(input logic [31:0] d, input logic [3:0] f);
        logic [39:0] v;
        v = {d, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v = v ^ (40'hB << (i - 3));
        return v[2:0];
    endfunction

    task automatic push_frame(input int id, input logic c, input logic [7:0] val, input int gap);
        frame_t f;
        f.is_ctl = c;
        f.val    = val;
        f.gap    = gap;
        if (id == 0) qa.push_back(f);
        else         qb.push_back(f);
    endtask

    task automatic push_data(input int id, input logic [31:0] d, input logic [3:0] f,
                             input logic [2:0] crc, input int first_gap);
        int g;
        g = (id == 0) ? 0 : 3;
        for (int i = 0; i < 4; i++)
            push_frame(id, 1'b0, d[31-8*i -: 8], (i == 0) ? first_gap : g);
        push_frame(id, 1'b1, {1'b0, f, crc}, g);
    endtask

    // Frame receiver: start bit opens a frame, 10 more bits close it
    task automatic monitor(input int id);
        bit         inframe;
        int         cnt;
        int         idle;
        logic [9:0] sh;
        logic       busy_all;
        logic       s, bz;
        frame_t     e;
        string      p;
        inframe = 0;
        cnt     = 0;
        idle    = 0;
        sh      = '0;
        busy_all = 1'b1;
        p = (id == 0) ? "a_" : "b_";
        forever begin
            @(negedge clk);
            s  = (id == 0) ? sout_a : sout_b;
            bz = (id == 0) ? busy_a : busy_b;
            if (rst) begin
                inframe = 0;
                idle    = 0;
            end else if (!inframe) begin
                if (s === 1'b0) begin
                    inframe  = 1;
                    cnt      = 0;
                    busy_all = bz;
                end else begin
                    idle++;
                end
            end else begin
                sh = {sh[8:0], s};
                cnt++;
                busy_all = busy_all & bz;
                if (cnt == 10) begin
                    inframe = 0;
                    chk({p, "stop_bit"}, sh[0], 1'b1);
                    chk({p, "busy_in_frame"}, busy_all, 1'b1);
                    if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL %sframe: actual=unexpected frame 0x%0h required=none", p, sh[9:1]);
                    end else begin
                        e = (id == 0) ? qa.pop_front() : qb.pop_front();
                        chk({p, "frame"}, {sh[9], sh[8:1]}, {e.is_ctl, e.val});
                        if (e.gap >= 0) chk({p, "gap_bits"}, idle, e.gap);
                    end
                    idle = 0;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Handshake with inputs already set; checks start bit latency and ready-low duration
    task automatic send(input int id, input int exp_cycles, input string nm);
        int n;
        if (id == 0) va = 1'b1;
        else         vb = 1'b1;
        n = 0;
        while (((id == 0) ? ready_a : ready_b) !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_at_accept"}, (id == 0) ? ready_a : ready_b, 1'b1);
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
        chk({nm, "_start_bit"}, (id == 0) ? sout_a : sout_b, 1'b0);
        chk({nm, "_busy"},      (id == 0) ? busy_a : busy_b, 1'b1);
        chk({nm, "_ready_low"}, (id == 0) ? ready_a : ready_b, 1'b0);
        n = 1;
        while (n < 1000) begin
            @(negedge clk);
            if (((id == 0) ? ready_a : ready_b) === 1'b1) break;
            n++;
        end
        chk({nm, "_ready_low_clocks"}, n, exp_cycles);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_sout_a", sout_a, 1'b1);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_ready_a", ready_a, 1'b1);
        chk("rst_sout_b", sout_b, 1'b1);
        chk("rst_ready_b", ready_b, 1'b1);
        rst = 1'b0;

        // X on inputs while idle and not valid
        data = 'x; flags = 'x; err = 'x; is_err = 'x;
        repeat (3) @(negedge clk);
        chk("idle_x_sout", sout_a, 1'b1);

        // All-zero data, flags 0010: CTL byte 0x16
        data = 32'h0; flags = 4'b0010; is_err = 1'b0;
        push_data(0, 32'h0, 4'b0010, 3'b110, -1);
        send(0, 55 + RSP_GAP, "zero");

        // Error 010 -> 0xA5
        @(negedge clk);
        is_err = 1'b1; err = 3'b010; data = 'x; flags = 'x;
        push_frame(0, 1'b1, 8'hA5, -1);
        send(0, 11 + RSP_GAP, "err");

        @(negedge clk);
        data = 32'hDEADBEEF; flags = 4'b1001; is_err = 1'b0; err = 'x;
        push_data(0, 32'hDEADBEEF, 4'b1001, crc_model(32'hDEADBEEF, 4'b1001), -1);
        send(0, 55 + RSP_GAP, "dead");

        // valid held through a transmission with garbage inputs
        @(negedge clk);
        data = 32'h12345678; flags = 4'b0100; is_err = 1'b0;
        push_data(0, 32'h12345678, 4'b0100, crc_model(32'h12345678, 4'b0100), -1);
        va = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (ready_a === 1'b1) break;
            n++;
            data = 'x; flags = 'x; err = 'x; is_err = 'x;
        end
        chk("hold_ready_low_clocks", n, 55 + RSP_GAP);
        data = 32'hA5A50F0F; flags = 4'b0001; is_err = 1'b0;
        push_data(0, 32'hA5A50F0F, 4'b0001, crc_model(32'hA5A50F0F, 4'b0001), RSP_GAP + 1);
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        chk("hold2_start_bit", sout_a, 1'b0);
        n = 1;
        while (n < 1000) begin
            @(negedge clk);
            if (ready_a === 1'b1) break;
            n++;
        end
        chk("hold2_ready_low_clocks", n, 55 + RSP_GAP);

        // Reset during frame 2 bit 5 (d[4] of 0x0F = 0)
        @(negedge clk);
        data = 32'hCAFE0F0D; flags = 4'b0011; is_err = 1'b0;
        push_data(0, 32'hCAFE0F0D, 4'b0011, crc_model(32'hCAFE0F0D, 4'b0011), -1);
        va = 1'b1;
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        chk("pre_reset_bit", sout_a, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_sout", sout_a, 1'b1);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_ready", ready_a, 1'b1);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_sout", sout_a, 1'b1);

        // Error 101 -> {1,101,101,1} = 0xDB
        is_err = 1'b1; err = 3'b101; data = 'x; flags = 'x;
        push_frame(0, 1'b1, 8'hDB, -1);
        send(0, 11 + RSP_GAP, "err2");

        // IDLE_GAP=3 instance
        @(negedge clk);
        data = 32'h0F0F00FF; flags = 4'b1111; is_err = 1'b0;
        push_data(1, 32'h0F0F00FF, 4'b1111, crc_model(32'h0F0F00FF, 4'b1111), -1);
        send(1, 55 + 4 * 3 + RSP_GAP, "gap3");

        repeat (5) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
